// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master slice.
//   state_e      : frame sequencer state encoding
//   INIT_OPCODE  : opcode of the init frame queued by init_req / reset
//   INIT_FRAME   : full 32-bit init word {24'h0, INIT_OPCODE}
//   FRAME_BITS   : bits per SPI frame
//   WR_OK_BIT, RD_OK_BIT, PAYLOAD_LSB, PAYLOAD_W : layout of the MISO word
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD,
    GAP
  } state_e;

  localparam logic [7:0]  INIT_OPCODE = 8'h01;
  localparam int          FRAME_BITS  = 32;
  localparam logic [31:0] INIT_FRAME  = {24'h000000, INIT_OPCODE};

  localparam int WR_OK_BIT   = 5;
  localparam int RD_OK_BIT   = 6;
  localparam int PAYLOAD_LSB = 7;
  localparam int PAYLOAD_W   = 24;

endpackage

// File: rtl/spi_if.sv
// spi_if -- host-side request/response bundle of the SPI master.
//   tx_valid/tx_ready/tx_data : frame request handshake (tx_data[7:0] = opcode)
//   init_req                  : single-cycle pulse queueing an init frame
//   rx_valid                  : one-cycle pulse when a frame completes
//   rx_data/rx_payload        : raw MISO word and its payload field
//   rx_wr_ok/rx_rd_ok         : slave status bits of the last frame
//   busy                      : frame in progress (including inter-frame gap)
// Modports: master = host side, slave = SPI master block side.
interface spi_if;

  logic                                 tx_valid;
  logic                                 tx_ready;
  logic [spi_pkg::FRAME_BITS-1:0]       tx_data;
  logic                                 init_req;
  logic                                 rx_valid;
  logic [spi_pkg::FRAME_BITS-1:0]       rx_data;
  logic [spi_pkg::PAYLOAD_W-1:0]        rx_payload;
  logic                                 rx_wr_ok;
  logic                                 rx_rd_ok;
  logic                                 busy;

  modport master (
    output tx_valid, tx_data, init_req,
    input  tx_ready, rx_valid, rx_data, rx_payload, rx_wr_ok, rx_rd_ok, busy
  );

  modport slave (
    input  tx_valid, tx_data, init_req,
    output tx_ready, rx_valid, rx_data, rx_payload, rx_wr_ok, rx_rd_ok, busy
  );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen -- SCK half-period generator.
//   clk, reset : system clock, synchronous active-high reset
//   en         : run the half-period counter; low forces SCK low and restarts
//   sck        : registered SPI clock (idles low)
//   rise/fall  : one-cycle strobes in the last cycle of a low/high half-period;
//                SCK changes level on the clock edge that ends that cycle
module spi_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] cnt_q;
  logic       sck_q;
  logic       half_done;

  assign half_done = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise      = half_done && !sck_q;
  assign fall      = half_done && sck_q;
  assign sck       = sck_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (half_done) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master -- mode-0, LSB-first, 32-bit frame SPI master.
//   clk, reset : system clock, synchronous active-high reset
//   SPI_SCK    : SPI clock, idles low
//   SPI_SS     : slave select, active low
//   SPI_MOSI   : serial data out, frame bit 0 first
//   SPI_MISO   : serial data in (asynchronous, two-flop synchronised)
//   host       : spi_if.slave request/response bundle
// Frame: SS falls, SS_GUARD cycles of setup, 32 SCK pulses of 2*CLK_DIV cycles,
// SS_GUARD cycles of hold, SS rises, then an SS_GUARD-cycle gap. An init frame
// is pending out of reset and always wins over a host request.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int SS_GUARD = 8
) (
  input  logic  clk,
  input  logic  reset,
  output logic  SPI_SCK,
  output logic  SPI_SS,
  output logic  SPI_MOSI,
  input  logic  SPI_MISO,
  spi_if.slave  host
);

  state_e                  state_q, state_n;
  logic                    ss_q, ss_n;
  logic [7:0]              gcnt_q;
  logic                    guard_done;
  logic [5:0]              bit_cnt_q;
  logic                    init_pend_q;
  logic [FRAME_BITS-1:0]   tx_sh_q;
  logic [FRAME_BITS-1:0]   rx_sh_q;
  logic [FRAME_BITS-1:0]   rx_data_q;
  logic                    rx_valid_q;
  logic                    miso_p0, miso_p1;
  logic                    sck_en, sck_rise, sck_fall, sck_int;
  logic                    start, start_init, tx_accept, cap_rx;
  logic [FRAME_BITS-1:0]   start_word;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sck_en),
    .sck  (sck_int),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // A same-cycle init_req masks tx_ready so the host request is deferred
  // behind the init frame instead of racing it.
  assign host.tx_ready = (state_q == IDLE) && !init_pend_q && !host.init_req;
  assign tx_accept     = host.tx_ready && host.tx_valid;
  assign start_init    = (state_q == IDLE) && init_pend_q;
  assign start         = start_init || tx_accept;
  assign start_word    = start_init ? INIT_FRAME : host.tx_data;

  assign guard_done = (gcnt_q == 8'(SS_GUARD - 1));
  assign sck_en     = (state_q == SCK_LO) || (state_q == SCK_HI);
  // Received word is published on the first GAP cycle, one cycle after SS rises.
  assign cap_rx     = (state_q == GAP) && (gcnt_q == 8'd0);

  always_comb begin
    state_n = state_q;
    ss_n    = ss_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          ss_n    = 1'b0;
        end
      end
      SETUP: begin
        if (guard_done) state_n = SCK_LO;
      end
      SCK_LO: begin
        if (sck_rise) state_n = SCK_HI;
      end
      SCK_HI: begin
        // Last falling edge goes straight to HOLD: no 33rd pulse.
        if (sck_fall) begin
          state_n = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? HOLD : SCK_LO;
        end
      end
      HOLD: begin
        if (guard_done) begin
          state_n = GAP;
          ss_n    = 1'b1;
        end
      end
      GAP: begin
        if (guard_done) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        ss_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      ss_q    <= ss_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt_q      <= '0;
      bit_cnt_q   <= '0;
      init_pend_q <= 1'b1;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      tx_sh_q     <= '0;
    end else begin
      if (state_n != state_q) begin
        gcnt_q <= '0;
      end else if ((state_q == SETUP) || (state_q == HOLD) || (state_q == GAP)) begin
        gcnt_q <= gcnt_q + 8'd1;
      end

      if (start) begin
        bit_cnt_q <= '0;
      end else if (sck_fall) begin
        bit_cnt_q <= bit_cnt_q + 6'd1;
      end

      // One-deep pending flag: pulses merge; a pulse on the service cycle
      // re-arms it.
      if (start_init) begin
        init_pend_q <= host.init_req;
      end else begin
        init_pend_q <= init_pend_q || host.init_req;
      end

      // MOSI is tx_sh_q[0]; shifting on each falling edge presents bit k+1.
      if (start) begin
        tx_sh_q <= start_word;
      end else if (sck_fall) begin
        tx_sh_q <= {1'b0, tx_sh_q[FRAME_BITS-1:1]};
      end

      rx_valid_q <= cap_rx;
      if (cap_rx) rx_data_q <= rx_sh_q;
    end
  end

  // MISO synchroniser: p0 -> p1
  always_ff @(posedge clk) begin
    miso_p0 <= SPI_MISO;
    miso_p1 <= miso_p0;
  end

  // Receive shift: bit k lands in position k after 32 falling edges.
  always_ff @(posedge clk) begin
    if (sck_fall) rx_sh_q <= {miso_p1, rx_sh_q[FRAME_BITS-1:1]};
  end

  assign SPI_SCK  = sck_int;
  assign SPI_SS   = ss_q;
  assign SPI_MOSI = tx_sh_q[0];

  assign host.busy       = (state_q != IDLE);
  assign host.rx_valid   = rx_valid_q;
  assign host.rx_data    = rx_data_q;
  assign host.rx_payload = rx_data_q[PAYLOAD_LSB +: PAYLOAD_W];
  assign host.rx_wr_ok   = rx_data_q[WR_OK_BIT];
  assign host.rx_rd_ok   = rx_data_q[RD_OK_BIT];

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed bench for spi_master with a mode-0 slave model.
module tb_spi_master;

  localparam int          CLK_DIV     = 4;
  localparam int          SS_GUARD    = 4;
  localparam logic [31:0] STATUS_WORD = {1'b0, 24'hCAFE77, 2'b11, 5'b00000};

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic SPI_MISO = 1'b0;
  logic SPI_SCK, SPI_SS, SPI_MOSI;

  spi_if u_if();

  spi_master #(
    .CLK_DIV (CLK_DIV),
    .SS_GUARD(SS_GUARD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .SPI_SCK (SPI_SCK),
    .SPI_SS  (SPI_SS),
    .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO),
    .host    (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Slave model / bus monitor state (written only by the monitor process).
  logic [31:0] resp = '0;
  logic [31:0] s_word = '0;
  int          s_idx = 0, sck_pulses = 0, ss_low = 0, ss_hi = 0;
  int          gap_min = 1000, aborts = 0, rv_cnt = 0, sck_stray = 0;
  bit          gap_armed = 0;
  logic        ss_prev = 1'b1, sck_prev = 1'b0;
  logic [31:0] fr_q[$];
  int          fr_bits[$], fr_sck[$], fr_len[$];

  always @(negedge clk) begin
    if (u_if.rx_valid) rv_cnt++;
    if (reset) gap_armed = 0;
    if (!ss_prev && SPI_SS) begin
      if (reset) begin
        aborts++;
      end else begin
        fr_q.push_back(s_word);
        fr_bits.push_back(s_idx);
        fr_sck.push_back(sck_pulses);
        fr_len.push_back(ss_low);
        gap_armed = 1;
      end
      ss_hi = 0;
    end
    if (ss_prev && !SPI_SS) begin
      if (gap_armed && ss_hi < gap_min) gap_min = ss_hi;
      s_idx = 0; s_word = '0; sck_pulses = 0; ss_low = 0;
      SPI_MISO = resp[0];
    end
    if (!SPI_SS && !sck_prev && SPI_SCK) begin
      if (s_idx < 32) s_word[s_idx] = SPI_MOSI;
      s_idx++;
      sck_pulses++;
    end
    if (!SPI_SS && sck_prev && !SPI_SCK) SPI_MISO = (s_idx < 32) ? resp[s_idx] : 1'b0;
    if (SPI_SS && !sck_prev && SPI_SCK) sck_stray++;
    if (SPI_SS) ss_hi++; else ss_low++;
    ss_prev  = SPI_SS;
    sck_prev = SPI_SCK;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input int budget);
    int n = 0;
    u_if.tx_data  = w;
    u_if.tx_valid = 1'b1;
    while (!u_if.tx_ready && n < budget) begin tick(); n++; end
    chk("send_ready", 32'(u_if.tx_ready), 32'd1);
    tick();
    u_if.tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (fr_q.size() < target && n < budget) begin tick(); n++; end
    chk("frame_count", 32'(fr_q.size()), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (u_if.busy && n < budget) begin tick(); n++; end
    chk("idle", 32'(u_if.busy), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, rv0, ab0;
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = '0;
    u_if.init_req = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_ss",       32'(SPI_SS),        32'd1);
    chk("rst_sck",      32'(SPI_SCK),       32'd0);
    chk("rst_mosi",     32'(SPI_MOSI),      32'd0);
    chk("rst_busy",     32'(u_if.busy),     32'd0);
    chk("rst_rx_valid", 32'(u_if.rx_valid), 32'd0);
    chk("rst_rx_data",  u_if.rx_data,       32'd0);
    chk("rst_tx_ready", 32'(u_if.tx_ready), 32'd0);
    reset = 1'b0;
    chk("init_pend_ready", 32'(u_if.tx_ready), 32'd0);
    tick();
    chk("init_busy", 32'(u_if.busy), 32'd1);

    // First frame after reset is the init frame
    wait_frames(1, 2000);
    wait_idle(100);
    chk("init_word",   fr_q[0],          32'h00000001);
    chk("init_bits",   32'(fr_bits[0]),  32'd32);
    chk("init_sck",    32'(fr_sck[0]),   32'd32);
    chk("init_ss_len", 32'(fr_len[0]),   32'd264);
    chk("init_rv",     32'(rv_cnt),      32'd1);
    chk("init_rxdata", u_if.rx_data,     32'd0);
    chk("init_wr_ok",  32'(u_if.rx_wr_ok), 32'd0);
    chk("idle_ready",  32'(u_if.tx_ready), 32'd1);

    // Status/payload response from the slave
    resp = STATUS_WORD;
    send(32'h12345602, 100);
    wait_frames(2, 2000);
    wait_idle(100);
    chk("st_slave_word", fr_q[1],               32'h12345602);
    chk("st_payload",    32'(u_if.rx_payload),  32'h00CAFE77);
    chk("st_wr_ok",      32'(u_if.rx_wr_ok),    32'd1);
    chk("st_rd_ok",      32'(u_if.rx_rd_ok),    32'd1);
    chk("st_rxdata",     u_if.rx_data,          32'h657F3BE0);
    chk("st_rv",         32'(rv_cnt),           32'd2);
    chk("st_ss_len",     32'(fr_len[1]),        32'd264);
    repeat (20) tick();
    chk("st_rx_hold",    u_if.rx_data,          32'h657F3BE0);

    // tx_valid held through a frame: exactly two back-to-back frames
    resp = '0;
    u_if.tx_data  = 32'hA5A5A5A5;
    u_if.tx_valid = 1'b1;
    wait_frames(3, 2000);
    n = 0;
    while (SPI_SS && n < 100) begin tick(); n++; end
    chk("b2b_second_start", 32'(SPI_SS), 32'd0);
    u_if.tx_valid = 1'b0;
    wait_frames(4, 2000);
    wait_idle(100);
    repeat (50) tick();
    chk("b2b_count",  32'(fr_q.size()), 32'd4);
    chk("b2b_word0",  fr_q[2], 32'hA5A5A5A5);
    chk("b2b_word1",  fr_q[3], 32'hA5A5A5A5);
    chk("b2b_gap",    32'(gap_min >= SS_GUARD), 32'd1);
    chk("b2b_stray",  32'(sck_stray), 32'd0);
    chk("b2b_rxdata", u_if.rx_data, 32'd0);

    // Reset in the middle of bit 17
    send(32'hDEADBEEF, 100);
    n = 0;
    while (s_idx != 17 && n < 1000) begin tick(); n++; end
    chk("mid_bit17", 32'(s_idx), 32'd17);
    base  = fr_q.size();
    rv0   = rv_cnt;
    ab0   = aborts;
    reset = 1'b1;
    tick();
    chk("mid_ss",   32'(SPI_SS),  32'd1);
    chk("mid_sck",  32'(SPI_SCK), 32'd0);
    chk("mid_busy", 32'(u_if.busy), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    wait_frames(base + 1, 2000);
    wait_idle(100);
    chk("mid_abort",    32'(aborts), 32'(ab0 + 1));
    chk("mid_next",     fr_q[base], 32'h00000001);
    chk("mid_rv",       32'(rv_cnt), 32'(rv0 + 1));

    // init_req with tx_valid on the same cycle, plus a repeated init during it
    base = fr_q.size();
    u_if.init_req = 1'b1;
    u_if.tx_data  = 32'h0000AB03;
    u_if.tx_valid = 1'b1;
    tick();
    u_if.init_req = 1'b0;
    chk("coll_ready", 32'(u_if.tx_ready), 32'd0);
    n = 0;
    while (SPI_SS && n < 100) begin tick(); n++; end
    chk("coll_init_start", 32'(SPI_SS), 32'd0);
    repeat (20) tick();
    u_if.init_req = 1'b1;
    tick();
    u_if.init_req = 1'b0;
    repeat (10) tick();
    u_if.init_req = 1'b1;
    tick();
    u_if.init_req = 1'b0;
    n = 0;
    while (!u_if.tx_ready && n < 3000) begin tick(); n++; end
    chk("coll_accept", 32'(u_if.tx_ready), 32'd1);
    tick();
    u_if.tx_valid = 1'b0;
    wait_frames(base + 3, 3000);
    wait_idle(100);
    repeat (50) tick();
    chk("coll_count",  32'(fr_q.size()), 32'(base + 3));
    chk("coll_word0",  fr_q[base],     32'h00000001);
    chk("coll_word1",  fr_q[base + 1], 32'h00000001);
    chk("coll_word2",  fr_q[base + 2], 32'h0000AB03);
    chk("zero_rxdata", u_if.rx_data,   32'd0);
    chk("zero_wr_ok",  32'(u_if.rx_wr_ok), 32'd0);
    chk("final_gap",   32'(gap_min >= SS_GUARD), 32'd1);
    chk("final_stray", 32'(sck_stray), 32'd0);
    chk("final_rv",    32'(rv_cnt), 32'(fr_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
